bin_to_bcd_serial: RTL and testbench



---
 rtl/bin_to_bcd_serial.sv | 161 ++++++++++++++++
 tb/tb_bin_to_bcd_serial.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_serial
//
// Serial double-dabble converter: turns an unsigned binary value into packed
// BCD for the seven-segment display path, one input bit per clock. It also
// reports how many digits are significant, which the display uses for
// leading-zero blanking and for choosing the exponent format.
//
// Ports
//   clk          system clock, everything on the rising edge
//   rst_n        synchronous, active-low reset
//   start        conversion request, only looked at while idle
//   bin          unsigned binary input, captured on the accepted start edge
//   busy         high while a conversion is running
//   done         one-cycle pulse when bcd / digit_count carry a new result
//   bcd          packed BCD, digit 0 (least significant) in bits [3:0]
//   digit_count  number of significant digits, 1..DIGITS (zero reports 1)
//
// Timing: start accepted at edge k, WIDTH shift edges k+1..k+WIDTH, done is
// high in the cycle after edge k+WIDTH. bcd and digit_count only change on
// that final edge, so the display never sees a partial result.
// -----------------------------------------------------------------------------
module bin_to_bcd_serial #(
    parameter int WIDTH  = 30,
    parameter int DIGITS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 bin,
    output logic                             busy,
    output logic                             done,
    output logic [4*DIGITS-1:0]              bcd,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count
);

    localparam int BW  = 4 * DIGITS;          // BCD field width
    localparam int SW  = BW + WIDTH;          // full {bcd, bin} shift register
    localparam int CW  = $clog2(WIDTH + 1);   // bit counter width
    localparam int DCW = $clog2(DIGITS + 1);  // digit_count width

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // The BCD field must be able to hold the largest binary input, i.e.
    // 10^DIGITS > 2^WIDTH - 1. Evaluated with wide arithmetic at elaboration.
    function automatic bit cfg_legal();
        logic [255:0] pow10;
        logic [255:0] max_bin;
        pow10 = 256'd1;
        for (int i = 0; i < DIGITS; i++) begin
            pow10 = pow10 * 256'd10;
        end
        max_bin = (256'd1 << WIDTH) - 256'd1;
        return pow10 > max_bin;
    endfunction

    localparam bit CFG_OK = cfg_legal();

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("bin_to_bcd_serial: DIGITS too small for WIDTH (need 10^DIGITS > 2^WIDTH-1)");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]       state_reg;
    logic [SW-1:0]    sr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [BW-1:0]    bcd_reg;
    logic [DCW-1:0]   dc_reg;

    // -------------------------------------------------------------------------
    // Datapath: add-3 on every nibble >= 5, then shift left by one
    // -------------------------------------------------------------------------
    logic [BW-1:0]    adj_bcd;
    logic [SW-1:0]    sr_next;
    logic [BW-1:0]    bcd_next;
    logic [DCW-1:0]   dc_next;
    logic [DIGITS-1:0] nib_ok;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
            logic [3:0] nib;
            assign nib = sr_reg[WIDTH + 4*gi +: 4];
            assign adj_bcd[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
            // After add-3 and shift, a nibble that started at 0..9 stays 0..9.
            assign nib_ok[gi] = (sr_next[WIDTH + 4*gi +: 4] <= 4'd9);
        end
    endgenerate

    // The bit shifted out of the top is always 0 for a legal configuration.
    always_comb begin
        sr_next  = {adj_bcd, sr_reg[WIDTH-1:0]} << 1;
        bcd_next = sr_next[SW-1:WIDTH];
    end

    // Significant digit count: position of the highest non-zero nibble + 1,
    // with an all-zero value still showing a single '0'.
    always_comb begin
        dc_next = DCW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                dc_next = DCW'(i + 1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sr_reg    <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            bcd_reg   <= '0;
            dc_reg    <= DCW'(1);
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (start) begin
                    sr_reg    <= {{BW{1'b0}}, bin};
                    cnt_reg   <= CW'(WIDTH);
                    busy_reg  <= 1'b1;
                    state_reg <= ST_SHIFT;
                end
            end else begin
                sr_reg  <= sr_next;
                cnt_reg <= cnt_reg - CW'(1);
                // Counter reaches zero on this edge: publish the result.
                if (cnt_reg == CW'(1)) begin
                    bcd_reg   <= bcd_next;
                    dc_reg    <= dc_next;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            end
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign bcd         = bcd_reg;
    assign digit_count = dc_reg;

    // Every intermediate nibble stays a valid decimal digit.
    a_nibble_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_reg == ST_SHIFT) |-> (&nib_ok)
    );

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_serial
//
// Self-checking bench for bin_to_bcd_serial (WIDTH=30, DIGITS=10): a table of
// hand-computed vectors run back to back, hand-written sequences for start
// while busy and reset mid-conversion, then random values checked against a
// divide-by-ten reference.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_serial;

    localparam int WIDTH  = 30;
    localparam int DIGITS = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [WIDTH-1:0]      bin_i;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [3:0]            digit_count;

    int n_checks;
    int n_errors;

    bin_to_bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bin         (bin_i),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .digit_count (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] bin;
        logic [39:0] bcd;
        logic [3:0]  dc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Divide-by-ten reference for the random run.
    function automatic logic [39:0] ref_bcd(input logic [29:0] v);
        logic [39:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_dc(input logic [29:0] v);
        int unsigned x;
        logic [3:0] n;
        x = v;
        n = 4'd1;
        while (x >= 10) begin
            x = x / 10;
            n = n + 4'd1;
        end
        return n;
    endfunction

    // Call right after a negedge. Issues start, then watches until done.
    // With poke set, start is pulsed (bin=5) at cycles 3, 10 and 20.
    task automatic run_conv(input logic [29:0] v, input logic poke,
                            output logic [39:0] got_bcd, output logic [3:0] got_dc,
                            output int lat, output int busy_cyc,
                            output int hold_bad, output int nib_bad);
        logic [39:0] prev;
        prev     = bcd;
        lat      = 0;
        busy_cyc = 0;
        hold_bad = 0;
        nib_bad  = 0;
        got_bcd  = '0;
        got_dc   = '0;
        start    = 1'b1;
        bin_i    = v;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            bin_i = ~v;   // bin only matters on the accepted edge
            if (poke && (c == 3 || c == 10 || c == 20)) begin
                start = 1'b1;
                bin_i = 30'd5;
            end
            for (int n = 0; n < 10; n++) begin
                if (bcd[4*n +: 4] > 4'd9) nib_bad++;
            end
            if (done) begin
                lat     = c;
                got_bcd = bcd;
                got_dc  = digit_count;
                break;
            end
            if (busy) busy_cyc++;
            if (bcd !== prev) hold_bad++;
        end
        start = 1'b0;
    endtask

    task automatic check_conv(input logic [29:0] v, input logic [39:0] eb,
                              input logic [3:0] ed, input logic poke);
        logic [39:0] gb;
        logic [3:0]  gd;
        int lat, bc, hb, nb;
        run_conv(v, poke, gb, gd, lat, bc, hb, nb);
        chk("latency",      64'(lat), 64'd31);
        chk("busy_cycles",  64'(bc),  64'd30);
        chk("bcd",          64'(gb),  64'(eb));
        chk("digit_count",  64'(gd),  64'(ed));
        chk("hold_output",  64'(hb),  64'd0);
        chk("nibble_range", 64'(nb),  64'd0);
        $display("conv bin=%0d bcd=%h dc=%0d lat=%0d", v, gb, gd, lat);
    endtask

    initial begin
        int extra_done;
        logic [29:0] rv;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin_i    = '0;

        vecs[0]  = '{30'd0,          40'h00_0000_0000, 4'd1};
        vecs[1]  = '{30'd123456789,  40'h01_2345_6789, 4'd9};
        vecs[2]  = '{30'd100000000,  40'h01_0000_0000, 4'd9};
        vecs[3]  = '{30'h3FFF_FFFF,  40'h10_7374_1823, 4'd10};
        vecs[4]  = '{30'd1,          40'h00_0000_0001, 4'd1};
        vecs[5]  = '{30'd9,          40'h00_0000_0009, 4'd1};
        vecs[6]  = '{30'd10,         40'h00_0000_0010, 4'd2};
        vecs[7]  = '{30'd99,         40'h00_0000_0099, 4'd2};
        vecs[8]  = '{30'd100,        40'h00_0000_0100, 4'd3};
        vecs[9]  = '{30'd999999999,  40'h09_9999_9999, 4'd9};
        vecs[10] = '{30'd1000000000, 40'h10_0000_0000, 4'd10};
        vecs[11] = '{30'd42,         40'h00_0000_0042, 4'd2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy),        64'd0);
        chk("rst_done", 64'(done),        64'd0);
        chk("rst_bcd",  64'(bcd),         64'd0);
        chk("rst_dc",   64'(digit_count), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Table, back to back (each start lands on the previous done cycle)
        for (int i = 0; i < 12; i++) begin
            check_conv(vecs[i].bin, vecs[i].bcd, vecs[i].dc, 1'b0);
        end

        // 42 then 999 started on the done cycle; bcd holds 0042 meanwhile
        check_conv(30'd42,  40'h00_0000_0042, 4'd2, 1'b0);
        check_conv(30'd999, 40'h00_0000_0999, 4'd3, 1'b0);

        // start pulses while busy are ignored
        check_conv(30'd77, 40'h00_0000_0077, 4'd2, 1'b1);
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        chk("no_extra_done", 64'(extra_done), 64'd0);
        chk("bcd_after_poke", 64'(bcd), 64'h00_0000_0077);
        $display("poke sequence extra_done=%0d", extra_done);

        // Reset at cycle 15 of a conversion aborts it
        start = 1'b1;
        bin_i = 30'd12345;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("busy_mid_conv", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy),        64'd0);
        chk("abort_done", 64'(done),        64'd0);
        chk("abort_bcd",  64'(bcd),         64'd0);
        chk("abort_dc",   64'(digit_count), 64'd1);
        rst_n = 1'b1;
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        chk("abort_quiet", 64'(extra_done), 64'd0);
        $display("reset abort sequence quiet_violations=%0d", extra_done);
        check_conv(30'd12345, 40'h00_0001_2345, 4'd5, 1'b0);

        // Random values against the divide-by-ten reference
        for (int i = 0; i < 1000; i++) begin
            case (i % 4)
                0:       rv = 30'($urandom);
                1:       rv = 30'($urandom_range(0, 9999));
                2:       rv = 30'($urandom_range(0, 99));
                default: rv = 30'($urandom) | 30'h2000_0000;
            endcase
            check_conv(rv, ref_bcd(rv), ref_dc(rv), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
